uart_tx_arbiter: RTL and testbench

//  Shares the single simplex UART transmitter between NumReq byte-stream requesters (VGA frame dump, debug/status).

---
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-atomic sharing of one UART byte
// transmitter between NumReq requesters. Each packet is framed as
// SYNC, HDR({4'hC,id}), LEN, payload[LEN], CSUM (XOR of payload).
// A payload stall of TimeoutCycles free-slot cycles aborts the packet:
// the rest is zero-filled and the checksum is inverted.
module uart_tx_arbiter #(
  parameter int         NumReq        = 2,
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         TimeoutCycles = 65535
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NumReq-1:0]      i_req,
  input  logic [NumReq-1:0][7:0] i_len,
  input  logic [NumReq-1:0]      i_valid,
  input  logic [NumReq-1:0][7:0] i_data,
  output logic [NumReq-1:0]      o_ack,
  output logic [NumReq-1:0]      o_grant,
  output logic                   o_uart_valid,
  output logic [7:0]             o_uart_frame,
  input  logic                   i_uart_ready,
  output logic                   o_busy,
  output logic                   o_abort
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int ToW  = $clog2(TimeoutCycles + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TimeoutCycles);

  typedef enum logic [2:0] {
    IDLE, SYNC, HDR, LEN, PAYLOAD, CSUM, DONE
  } state_t;

  state_t               state, stateNxt;
  logic [IdxW-1:0]      rrPtr, rrPtrNxt;
  logic [IdxW-1:0]      gIdx, gIdxNxt;
  logic [IdxW-1:0]      winIdx, cIdx;
  logic                 winFound;
  logic [NumReq-1:0]    grantNxt;
  logic [7:0]           lenQ, lenNxt;
  logic [7:0]           acc, accNxt;
  logic [7:0]           payCnt, payCntNxt;
  logic [ToW-1:0]       toCnt, toCntNxt;
  logic                 aborted, abortedNxt, abortNxt;
  logic                 slotFree, haveByte, load, ackLoad;
  logic [7:0]           byteNxt;
  logic                 gValid;
  logic [7:0]           gData;

  // The slot can take a new byte when empty or being drained this cycle.
  assign slotFree = !o_uart_valid || i_uart_ready;
  assign gValid   = i_valid[gIdx];
  assign gData    = i_data[gIdx];
  assign load     = slotFree && haveByte;
  assign o_busy   = (state != IDLE) || o_uart_valid;

  // Round-robin search: first requester after the pointer, wrapping.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cIdx     = '0;
    for (int k = 0; k < NumReq; k++) begin
      cIdx = IdxW'((int'(rrPtr) + k + 1) % NumReq);
      if (!winFound && i_req[cIdx]) begin
        winFound = 1'b1;
        winIdx   = cIdx;
      end
    end
  end

  // Next state, next frame byte and per-packet bookkeeping.
  always_comb begin
    stateNxt   = state;
    rrPtrNxt   = rrPtr;
    gIdxNxt    = gIdx;
    grantNxt   = o_grant;
    lenNxt     = lenQ;
    accNxt     = acc;
    payCntNxt  = payCnt;
    toCntNxt   = toCnt;
    abortedNxt = aborted;
    abortNxt   = 1'b0;
    haveByte   = 1'b0;
    ackLoad    = 1'b0;
    byteNxt    = '0;
    case (state)
      IDLE: begin
        if (winFound) begin
          stateNxt   = SYNC;
          rrPtrNxt   = winIdx;
          gIdxNxt    = winIdx;
          grantNxt   = NumReq'(1) << winIdx;
          lenNxt     = i_len[winIdx];
          accNxt     = '0;
          payCntNxt  = '0;
          toCntNxt   = '0;
          abortedNxt = 1'b0;
        end
      end
      SYNC: begin
        haveByte = 1'b1;
        byteNxt  = SyncByte;
        if (slotFree) stateNxt = HDR;
      end
      HDR: begin
        haveByte = 1'b1;
        byteNxt  = {4'hC, 4'(gIdx)};
        if (slotFree) stateNxt = LEN;
      end
      LEN: begin
        haveByte = 1'b1;
        byteNxt  = lenQ;
        if (slotFree) stateNxt = (lenQ == 8'd0) ? CSUM : PAYLOAD;
      end
      PAYLOAD: begin
        // After an abort the rest of the payload is zero fill, never acked.
        haveByte = aborted || gValid;
        byteNxt  = aborted ? 8'h00 : gData;
        if (slotFree) begin
          if (haveByte) begin
            ackLoad   = !aborted;
            accNxt    = acc ^ byteNxt;
            payCntNxt = payCnt + 8'd1;
            toCntNxt  = '0;
            if (({1'b0, payCnt} + 9'd1) == {1'b0, lenQ}) stateNxt = CSUM;
          end else if (!aborted) begin
            // Stall timer only runs while the UART could have taken a byte.
            if (toCnt != ToMax) toCntNxt = toCnt + ToW'(1);
            if (({1'b0, toCnt} + (ToW+1)'(1)) == {1'b0, ToMax}) begin
              abortNxt   = 1'b1;
              abortedNxt = 1'b1;
            end
          end
        end
      end
      CSUM: begin
        haveByte = 1'b1;
        byteNxt  = aborted ? ~acc : acc;
        if (slotFree) stateNxt = DONE;
      end
      DONE: begin
        // Hold the grant until the checksum has left the slot.
        if (slotFree) begin
          grantNxt = '0;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Only the owner is acked, and only on a real (non-fill) payload load.
  for (genvar n = 0; n < NumReq; n++) begin : g_ack
    assign o_ack[n] = ackLoad && o_grant[n];
  end

  // FSM and packet context registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      rrPtr   <= IdxW'(NumReq - 1);
      gIdx    <= '0;
      o_grant <= '0;
      lenQ    <= '0;
      acc     <= '0;
      payCnt  <= '0;
      toCnt   <= '0;
      aborted <= 1'b0;
      o_abort <= 1'b0;
    end else begin
      state   <= stateNxt;
      rrPtr   <= rrPtrNxt;
      gIdx    <= gIdxNxt;
      o_grant <= grantNxt;
      lenQ    <= lenNxt;
      acc     <= accNxt;
      payCnt  <= payCntNxt;
      toCnt   <= toCntNxt;
      aborted <= abortedNxt;
      o_abort <= abortNxt;
    end
  end

  // Registered output slot: load on free slot, hold under back-pressure.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_uart_valid <= 1'b0;
      o_uart_frame <= '0;
    end else if (load) begin
      o_uart_valid <= 1'b1;
      o_uart_frame <= byteNxt;
    end else if (i_uart_ready) begin
      o_uart_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester/UART drivers, a packet-level
// reference model (round-robin order, framing, checksum, timeout fill)
// and one task per scenario.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int TO = 8;

  logic                CLK, RST;
  logic [NR-1:0]       i_req, i_valid, o_ack, o_grant;
  logic [NR-1:0][7:0]  i_len, i_data;
  logic                o_uart_valid, i_uart_ready, o_busy, o_abort;
  logic [7:0]          o_uart_frame;

  uart_tx_arbiter #(.NumReq(NR), .SyncByte(8'hA5), .TimeoutCycles(TO)) dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_len(i_len), .i_valid(i_valid),
    .i_data(i_data), .o_ack(o_ack), .o_grant(o_grant), .o_uart_valid(o_uart_valid),
    .o_uart_frame(o_uart_frame), .i_uart_ready(i_uart_ready), .o_busy(o_busy),
    .o_abort(o_abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nTests = 0, nFail = 0, cyc = 0;
  logic [7:0] rxQ[$];
  int         rxCyc[$];
  int         grantLog[$];
  int         ackCnt[NR];
  int         lowRun[NR];
  int         abortCnt, abortCyc, lastAckCyc;
  logic [7:0] srcQ[NR][$];
  int         lenQ[NR][$];
  logic [7:0] planData[NR][$];
  int         planLens[NR][$];
  logic [7:0] expQ[$];
  int         expOrder[$];
  int         expAcks[NR];
  int         expAborts;
  int         mPtr = NR - 1;
  int         readyMode, validRandom;
  logic [NR-1:0] prevGrant;
  logic       prevValid, prevReady;
  logic [7:0] prevFrame;

  // Packet-level model: arbitration order, framed bytes, acks, aborts.
  function automatic void buildExpected();
    int pi[NR];
    int off[NR];
    bit more;
    int w, L, avail, c;
    logic [7:0] cs, b;
    expQ.delete();
    expOrder.delete();
    expAborts = 0;
    for (int n = 0; n < NR; n++) begin pi[n] = 0; off[n] = 0; expAcks[n] = 0; end
    more = 1'b1;
    while (more) begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (mPtr + k) % NR;
        if (w < 0 && pi[c] < planLens[c].size()) w = c;
      end
      if (w < 0) more = 1'b0;
      else begin
        mPtr = w;
        expOrder.push_back(w);
        L = planLens[w][pi[w]];
        pi[w]++;
        avail = planData[w].size() - off[w];
        if (avail > L) avail = L;
        cs = 8'h00;
        expQ.push_back(8'hA5);
        expQ.push_back(8'hC0 | 8'(w));
        expQ.push_back(8'(L));
        for (int i = 0; i < L; i++) begin
          b = (i < avail) ? planData[w][off[w] + i] : 8'h00;
          cs ^= b;
          expQ.push_back(b);
        end
        off[w] += avail;
        expAcks[w] += avail;
        if (avail < L) begin expAborts++; cs = ~cs; end
        expQ.push_back(cs);
      end
    end
  endfunction

  task automatic clearPlan();
    for (int n = 0; n < NR; n++) begin planData[n].delete(); planLens[n].delete(); end
  endtask

  // Drive requester and UART inputs just after the active edge.
  task automatic drive();
    for (int n = 0; n < NR; n++) begin
      logic v;
      i_req[n] = (lenQ[n].size() > 0);
      i_len[n] = (lenQ[n].size() > 0) ? 8'(lenQ[n][0]) : 8'h00;
      v = (srcQ[n].size() > 0);
      if (v && validRandom != 0 && lowRun[n] < 3 && $urandom_range(3) == 0) v = 1'b0;
      if (!v) lowRun[n]++;
      i_valid[n] = v;
      i_data[n] = (srcQ[n].size() > 0) ? srcQ[n][0] : 8'($urandom);
    end
    case (readyMode)
      0:       i_uart_ready = 1'b1;
      1:       i_uart_ready = !i_uart_ready;
      default: i_uart_ready = ($urandom_range(2) != 0);
    endcase
  endtask

  // One clock: sample outputs at the falling edge, then redrive inputs.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (o_uart_valid && i_uart_ready) begin rxQ.push_back(o_uart_frame); rxCyc.push_back(cyc); end
    if (prevValid && !prevReady) begin
      nTests++;
      if (o_uart_valid !== 1'b1 || o_uart_frame !== prevFrame) begin
        nFail++;
        $display("FAIL hold_stable got v=%b f=%h want v=1 f=%h", o_uart_valid, o_uart_frame, prevFrame);
      end
    end
    prevValid = o_uart_valid; prevReady = i_uart_ready; prevFrame = o_uart_frame;
    for (int n = 0; n < NR; n++) begin
      if (o_ack[n]) begin
        nTests++;
        if (!(o_grant[n] && i_valid[n]) || srcQ[n].size() == 0) begin
          nFail++;
          $display("FAIL ack_qual req%0d got grant=%b valid=%b want both 1", n, o_grant[n], i_valid[n]);
        end
        ackCnt[n]++; lastAckCyc = cyc; lowRun[n] = 0;
        if (srcQ[n].size() > 0) void'(srcQ[n].pop_front());
      end
      if (o_grant[n] && !prevGrant[n]) begin
        grantLog.push_back(n);
        if (lenQ[n].size() > 0) void'(lenQ[n].pop_front());
      end
    end
    prevGrant = o_grant;
    if (o_abort) begin abortCnt++; abortCyc = cyc; end
    @(posedge CLK);
    #1;
    drive();
  endtask

  task automatic loadPlan();
    buildExpected();
    rxQ.delete(); rxCyc.delete(); grantLog.delete();
    abortCnt = 0; abortCyc = 0; lastAckCyc = 0;
    for (int n = 0; n < NR; n++) begin
      srcQ[n] = planData[n]; lenQ[n] = planLens[n]; lowRun[n] = 0; ackCnt[n] = 0;
    end
    drive();
  endtask

  task automatic runPlan(output bit timedOut);
    int k;
    loadPlan();
    k = 0;
    do begin step(); k++; end while ((o_busy || i_req != '0) && k < 4000);
    timedOut = (k >= 4000);
  endtask

  task automatic test_reset();
    RST = 1'b0; i_req = '0; i_valid = '0; i_len = '0; i_data = '0; i_uart_ready = 1'b0;
    prevGrant = '0; prevValid = 1'b0; prevReady = 1'b0; prevFrame = '0;
    readyMode = 0; validRandom = 0;
    repeat (3) @(negedge CLK);
    nTests++; if (o_grant !== '0) begin nFail++; $display("FAIL reset_grant got %b want 0", o_grant); end
    nTests++; if (o_uart_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b want 0", o_uart_valid); end
    nTests++; if (o_uart_frame !== 8'h00) begin nFail++; $display("FAIL reset_frame got %h want 00", o_uart_frame); end
    nTests++; if (o_ack !== '0) begin nFail++; $display("FAIL reset_ack got %b want 0", o_ack); end
    nTests++; if (o_busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    nTests++; if (o_abort !== 1'b0) begin nFail++; $display("FAIL reset_abort got %b want 0", o_abort); end
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    bit to;
    clearPlan();
    planLens[0].push_back(3);
    planData[0].push_back(8'h11); planData[0].push_back(8'h22); planData[0].push_back(8'h33);
    readyMode = 0; validRandom = 0;
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL single_done got timeout want idle"); end
    nTests++; if (rxQ.size() != 7) begin nFail++; $display("FAIL single_len got %0d want 7", rxQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL single_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
    nTests++; if (rxQ.size() == 7 && rxQ[6] !== 8'h00) begin nFail++; $display("FAIL single_csum got %h want 00", rxQ[6]); end
    nTests++; if (ackCnt[0] != 3) begin nFail++; $display("FAIL single_acks got %0d want 3", ackCnt[0]); end
    nTests++;
    if (rxCyc.size() != 7 || rxCyc[rxCyc.size()-1] - rxCyc[0] != 6) begin
      nFail++; $display("FAIL single_rate got %0d bytes, span %0d want 7 bytes span 6", rxCyc.size(),
                        (rxCyc.size() > 0) ? rxCyc[rxCyc.size()-1] - rxCyc[0] : -1);
    end
    nTests++; if (o_busy !== 1'b0) begin nFail++; $display("FAIL single_busy got %b want 0", o_busy); end
  endtask

  task automatic test_rr();
    bit to;
    clearPlan();
    for (int n = 0; n < NR; n++)
      for (int p = 0; p < 3; p++) begin
        int L;
        L = $urandom_range(1, 6);
        planLens[n].push_back(L);
        for (int i = 0; i < L; i++) planData[n].push_back(8'($urandom));
      end
    readyMode = 0; validRandom = 0;
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL rr_done got timeout want idle"); end
    nTests++; if (grantLog.size() != 6) begin nFail++; $display("FAIL rr_count got %0d want 6", grantLog.size()); end
    for (int i = 0; i < grantLog.size() && i < expOrder.size(); i++) begin
      nTests++; if (grantLog[i] != expOrder[i]) begin nFail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, grantLog[i], expOrder[i]); end
      if (i > 0) begin
        nTests++; if (grantLog[i] == grantLog[i-1]) begin nFail++; $display("FAIL rr_alternate[%0d] got %0d want %0d", i, grantLog[i], 1 - grantLog[i-1]); end
      end
    end
    nTests++; if (rxQ.size() != expQ.size()) begin nFail++; $display("FAIL rr_len got %0d want %0d", rxQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL rr_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clearPlan();
    planLens[1].push_back(12);
    for (int i = 0; i < 12; i++) planData[1].push_back(8'($urandom));
    readyMode = 1; validRandom = 0;
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL bp_done got timeout want idle"); end
    nTests++; if (rxQ.size() != expQ.size()) begin nFail++; $display("FAIL bp_len got %0d want %0d", rxQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL bp_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
    nTests++; if (ackCnt[1] != 12) begin nFail++; $display("FAIL bp_acks got %0d want 12", ackCnt[1]); end
  endtask

  task automatic test_timeout();
    bit to;
    logic [7:0] b0, b1;
    clearPlan();
    b0 = 8'($urandom); b1 = 8'($urandom);
    planLens[1].push_back(4);
    planData[1].push_back(b0); planData[1].push_back(b1);
    readyMode = 0; validRandom = 0;
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL to_done got timeout want idle"); end
    nTests++; if (rxQ.size() != 8) begin nFail++; $display("FAIL to_len got %0d want 8", rxQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL to_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
    nTests++; if (rxQ.size() == 8 && rxQ[7] !== ~(b0 ^ b1)) begin nFail++; $display("FAIL to_csum got %h want %h", rxQ[7], ~(b0 ^ b1)); end
    nTests++; if (ackCnt[1] != 2) begin nFail++; $display("FAIL to_acks got %0d want 2", ackCnt[1]); end
    nTests++; if (abortCnt != 1) begin nFail++; $display("FAIL to_pulses got %0d want 1", abortCnt); end
    nTests++;
    if (abortCyc - lastAckCyc != TO + 1) begin
      nFail++; $display("FAIL to_delay got %0d want %0d", abortCyc - lastAckCyc, TO + 1);
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clearPlan();
    planLens[0].push_back(0);
    readyMode = 2; validRandom = 0;
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL zl_done got timeout want idle"); end
    nTests++; if (rxQ.size() != 4) begin nFail++; $display("FAIL zl_len got %0d want 4", rxQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL zl_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
    nTests++; if (ackCnt[0] != 0) begin nFail++; $display("FAIL zl_acks got %0d want 0", ackCnt[0]); end
  endtask

  task automatic test_random();
    bit to;
    for (int r = 0; r < 5; r++) begin
      clearPlan();
      for (int n = 0; n < NR; n++) begin
        int np, tot, sup;
        np = $urandom_range(0, 2);
        tot = 0;
        for (int p = 0; p < np; p++) begin
          int L;
          L = $urandom_range(0, 12);
          planLens[n].push_back(L);
          tot += L;
        end
        sup = ($urandom_range(3) == 0) ? $urandom_range(0, tot) : tot;
        for (int i = 0; i < sup; i++) planData[n].push_back(8'($urandom));
      end
      readyMode = 2; validRandom = 1;
      runPlan(to);
      nTests++; if (to) begin nFail++; $display("FAIL rnd%0d_done got timeout want idle", r); end
      nTests++; if (rxQ.size() != expQ.size()) begin nFail++; $display("FAIL rnd%0d_len got %0d want %0d", r, rxQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
        nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL rnd%0d_byte[%0d] got %h want %h", r, i, rxQ[i], expQ[i]); end
      end
      nTests++; if (grantLog.size() != expOrder.size()) begin nFail++; $display("FAIL rnd%0d_grants got %0d want %0d", r, grantLog.size(), expOrder.size()); end
      for (int i = 0; i < grantLog.size() && i < expOrder.size(); i++) begin
        nTests++; if (grantLog[i] != expOrder[i]) begin nFail++; $display("FAIL rnd%0d_order[%0d] got %0d want %0d", r, i, grantLog[i], expOrder[i]); end
      end
      for (int n = 0; n < NR; n++) begin
        nTests++; if (ackCnt[n] != expAcks[n]) begin nFail++; $display("FAIL rnd%0d_acks%0d got %0d want %0d", r, n, ackCnt[n], expAcks[n]); end
      end
      nTests++; if (abortCnt != expAborts) begin nFail++; $display("FAIL rnd%0d_aborts got %0d want %0d", r, abortCnt, expAborts); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k;
    clearPlan();
    planLens[1].push_back(30);
    for (int i = 0; i < 30; i++) planData[1].push_back(8'($urandom));
    readyMode = 0; validRandom = 0;
    loadPlan();
    k = 0;
    while (ackCnt[1] < 5 && k < 200) begin step(); k++; end
    nTests++; if (ackCnt[1] < 5) begin nFail++; $display("FAIL rm_reach got %0d acks want 5", ackCnt[1]); end
    #2;
    RST = 1'b0;
    #1;
    nTests++; if (o_uart_valid !== 1'b0) begin nFail++; $display("FAIL rm_valid got %b want 0", o_uart_valid); end
    nTests++; if (o_grant !== '0) begin nFail++; $display("FAIL rm_grant got %b want 0", o_grant); end
    nTests++; if (o_ack !== '0) begin nFail++; $display("FAIL rm_ack got %b want 0", o_ack); end
    nTests++; if (o_busy !== 1'b0) begin nFail++; $display("FAIL rm_busy got %b want 0", o_busy); end
    for (int n = 0; n < NR; n++) begin srcQ[n].delete(); lenQ[n].delete(); end
    mPtr = NR - 1;
    prevGrant = '0; prevValid = 1'b0;
    drive();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    clearPlan();
    for (int n = 0; n < NR; n++) begin planLens[n].push_back(1); planData[n].push_back(8'($urandom)); end
    runPlan(to);
    nTests++; if (to) begin nFail++; $display("FAIL rm_done got timeout want idle"); end
    nTests++;
    if (grantLog.size() == 0 || grantLog[0] != 0) begin
      nFail++; $display("FAIL rm_first got %0d want 0", (grantLog.size() > 0) ? grantLog[0] : -1);
    end
    nTests++; if (rxQ.size() != expQ.size()) begin nFail++; $display("FAIL rm_len got %0d want %0d", rxQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nTests++; if (rxQ[i] !== expQ[i]) begin nFail++; $display("FAIL rm_byte[%0d] got %h want %h", i, rxQ[i], expQ[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_timeout();
    test_zero_len();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
